// File: rtl/w_grf_writer_pkg.sv
// Shared widths and the buffered-result entry layout for the GRF writer.
package w_grf_writer_pkg;
  localparam int WB_DEPTH = 4;
  localparam int WB_PTR_W = 2;
  localparam int WB_A3_W  = 5;
  localparam int WB_D_W   = 32;
  localparam logic [WB_A3_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic              live;
    logic [WB_A3_W-1:0] a3;
    logic [WB_D_W-1:0]  wd;
    logic [WB_D_W-1:0]  pc;
  } wb_ent_t;
endpackage

// File: rtl/w_wb_fifo.sv
// Circular buffer of MDU results with per-entry live bits, kill-by-a3 and two pending matches.
// WB_TRACE_EN adds a warning whenever a live entry is killed.
module w_wb_fifo
  import w_grf_writer_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int PTR_W = WB_PTR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               push_live,
  input  logic [WB_A3_W-1:0] push_a3,
  input  logic [WB_D_W-1:0]  push_wd,
  input  logic [WB_D_W-1:0]  push_pc,
  input  logic               pop,
  output logic               head_live,
  output logic [WB_A3_W-1:0] head_a3,
  output logic [WB_D_W-1:0]  head_wd,
  output logic [WB_D_W-1:0]  head_pc,
  output logic               full,
  output logic               empty,
  input  logic               kill_en,
  input  logic [WB_A3_W-1:0] kill_a3,
`ifdef WB_TRACE_EN
  input  logic [WB_D_W-1:0]  kill_pc,
`endif
  input  logic [WB_A3_W-1:0] q_a1,
  input  logic [WB_A3_W-1:0] q_a2,
  output logic               pend1,
  output logic               pend2
);
  wb_ent_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;

  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign empty     = (count == '0);
  assign head_live = mem[rd_ptr].live;
  assign head_a3   = mem[rd_ptr].a3;
  assign head_wd   = mem[rd_ptr].wd;
  assign head_pc   = mem[rd_ptr].pc;

  // live is cleared on pop, so live alone marks an occupied, unkilled slot
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i].live <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (pop && rd_ptr == PTR_W'(i)) mem[i].live <= 1'b0;
        else if (kill_en && mem[i].live && mem[i].a3 == kill_a3) begin
          mem[i].live <= 1'b0;
`ifdef WB_TRACE_EN
          $display("WARN WAW kill: $%0d pc %h superseded by pc %h", kill_a3, mem[i].pc, kill_pc);
`endif
        end
        if (push && wr_ptr == PTR_W'(i)) mem[i] <= '{push_live, push_a3, push_wd, push_pc};
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  always_comb begin
    pend1 = 1'b0;
    pend2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem[i].live && mem[i].a3 == q_a1) pend1 = 1'b1;
      if (mem[i].live && mem[i].a3 == q_a2) pend2 = 1'b1;
    end
    if (q_a1 == REG_ZERO) pend1 = 1'b0;
    if (q_a2 == REG_ZERO) pend2 = 1'b0;
  end
endmodule

// File: rtl/w_grf_writer.sv
// GRF write-port driver: W-stage writeback first, then buffered/bypassed MDU results.
// WB_TRACE_EN enables a per-write trace line and WAW-kill warnings.
module w_grf_writer
  import w_grf_writer_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int PTR_W = WB_PTR_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  w_a3,
  input  logic [31:0] w_wd,
  input  logic [31:0] w_pc,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_a3,
  input  logic [31:0] mdu_wd,
  input  logic [31:0] mdu_pc,
  output logic [4:0]  grf_a3,
  output logic [31:0] grf_wd,
  output logic [31:0] grf_pc,
  input  logic [4:0]  q_a1,
  input  logic [4:0]  q_a2,
  output logic        q_pend1,
  output logic        q_pend2
);
  logic        full, empty, head_live;
  logic [4:0]  head_a3;
  logic [31:0] head_wd, head_pc;
  logic        w_sel, acc, pop, byp, push, push_live;
  logic [4:0]  nxt_a3;
  logic [31:0] nxt_wd, nxt_pc;
  logic        ld;

  assign mdu_ready = !full;
  assign w_sel     = (w_a3 != REG_ZERO);
  assign acc       = mdu_valid && mdu_ready;
  assign pop       = !w_sel && !empty;
  assign byp       = !w_sel && empty && acc && (mdu_a3 != REG_ZERO);
  assign push      = acc && (mdu_a3 != REG_ZERO) && !byp;
  // a push racing a W write to the same register is already stale
  assign push_live = !(w_sel && w_a3 == mdu_a3);

  w_wb_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
    .clk(clk), .reset(reset),
    .push(push), .push_live(push_live), .push_a3(mdu_a3), .push_wd(mdu_wd), .push_pc(mdu_pc),
    .pop(pop), .head_live(head_live), .head_a3(head_a3), .head_wd(head_wd), .head_pc(head_pc),
    .full(full), .empty(empty),
    .kill_en(w_sel), .kill_a3(w_a3),
`ifdef WB_TRACE_EN
    .kill_pc(w_pc),
`endif
    .q_a1(q_a1), .q_a2(q_a2), .pend1(q_pend1), .pend2(q_pend2)
  );

  always_comb begin
    nxt_a3 = REG_ZERO;
    nxt_wd = w_wd;
    nxt_pc = w_pc;
    ld     = 1'b0;
    if (w_sel) begin
      nxt_a3 = w_a3;
      ld     = 1'b1;
    end else if (!empty) begin
      nxt_a3 = head_live ? head_a3 : REG_ZERO;
      nxt_wd = head_wd;
      nxt_pc = head_pc;
      ld     = 1'b1;
    end else if (byp) begin
      nxt_a3 = mdu_a3;
      nxt_wd = mdu_wd;
      nxt_pc = mdu_pc;
      ld     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grf_a3 <= REG_ZERO;
      grf_wd <= '0;
      grf_pc <= '0;
    end else begin
      grf_a3 <= nxt_a3;
      if (ld) begin
        grf_wd <= nxt_wd;
        grf_pc <= nxt_pc;
      end
    end
  end

`ifdef WB_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset && grf_a3 != REG_ZERO)
      $display("%d@%h: $%d <= %h", $time, grf_pc, grf_a3, grf_wd);
    if (!reset && push && !push_live)
      $display("WARN WAW kill: $%0d pc %h superseded by pc %h", mdu_a3, mdu_pc, w_pc);
  end
`endif
endmodule

// File: tb/tb_w_grf_writer.sv
// Randomized plus directed bench for w_grf_writer against a queue-based reference model.
module tb_w_grf_writer;
  localparam int DEPTH = 4;

  logic        clk, reset;
  logic [4:0]  w_a3, mdu_a3, grf_a3, q_a1, q_a2;
  logic [31:0] w_wd, w_pc, mdu_wd, mdu_pc, grf_wd, grf_pc;
  logic        mdu_valid, mdu_ready, q_pend1, q_pend2;

  w_grf_writer dut (
    .clk(clk), .reset(reset),
    .w_a3(w_a3), .w_wd(w_wd), .w_pc(w_pc),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready),
    .mdu_a3(mdu_a3), .mdu_wd(mdu_wd), .mdu_pc(mdu_pc),
    .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc),
    .q_a1(q_a1), .q_a2(q_a2), .q_pend1(q_pend1), .q_pend2(q_pend2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          live;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  logic [4:0]  exp_a3;
  logic [31:0] exp_wd, exp_pc;
  logic [31:0] grf_shadow [32];
  int          n_cmp, n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit m_pend(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i].live && mq[i].a3 == a) return 1'b1;
    return 1'b0;
  endfunction

  // Sample registered outputs at negedge and fold committed writes into a GRF image.
  task automatic check_outputs();
    chk("grf_a3", 32'(grf_a3), 32'(exp_a3));
    if (exp_a3 != 5'd0) begin
      chk("grf_wd", grf_wd, exp_wd);
      chk("grf_pc", grf_pc, exp_pc);
    end
    if (grf_a3 != 5'd0) grf_shadow[grf_a3] = grf_wd;
  endtask

  // One cycle starting at a negedge: drive, check comb outputs, advance model, check registered outputs.
  task automatic cycle(input logic [4:0] wa3, input logic [31:0] wwd, input logic [31:0] wpc,
                       input logic mv, input logic [4:0] ma3, input logic [31:0] mwd,
                       input logic [31:0] mpc, input logic [4:0] qa1, input logic [4:0] qa2);
    bit acc, byp;
    w_a3 = wa3; w_wd = wwd; w_pc = wpc;
    mdu_valid = mv; mdu_a3 = ma3; mdu_wd = mwd; mdu_pc = mpc;
    q_a1 = qa1; q_a2 = qa2;
    #1;
    chk("q_pend1", 32'(q_pend1), 32'(m_pend(qa1)));
    chk("q_pend2", 32'(q_pend2), 32'(m_pend(qa2)));
    chk("mdu_ready", 32'(mdu_ready), 32'(mq.size() < DEPTH));
    acc = mv && (mq.size() < DEPTH);
    byp = 1'b0;
    if (wa3 != 5'd0) begin
      foreach (mq[i]) if (mq[i].a3 == wa3) mq[i].live = 1'b0;
      exp_a3 = wa3; exp_wd = wwd; exp_pc = wpc;
    end else if (mq.size() > 0) begin
      ent_t h = mq.pop_front();
      exp_a3 = h.live ? h.a3 : 5'd0; exp_wd = h.wd; exp_pc = h.pc;
    end else if (acc && ma3 != 5'd0) begin
      byp = 1'b1;
      exp_a3 = ma3; exp_wd = mwd; exp_pc = mpc;
    end else exp_a3 = 5'd0;
    if (acc && ma3 != 5'd0 && !byp)
      mq.push_back('{live: !(wa3 == ma3), a3: ma3, wd: mwd, pc: mpc});
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input logic [4:0] qa1, input logic [4:0] qa2);
    cycle(5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, qa1, qa2);
  endtask

  task automatic do_reset(input logic [4:0] qa1, input logic [4:0] qa2);
    reset = 1'b1;
    w_a3 = 5'd0; mdu_valid = 1'b0; mdu_a3 = 5'd0; q_a1 = qa1; q_a2 = qa2;
    @(posedge clk);
    @(negedge clk);
    mq.delete();
    exp_a3 = 5'd0; exp_wd = 32'd0; exp_pc = 32'd0;
    chk("rst_grf_a3", 32'(grf_a3), 32'd0);
    chk("rst_grf_wd", grf_wd, 32'd0);
    chk("rst_grf_pc", grf_pc, 32'd0);
    chk("rst_ready", 32'(mdu_ready), 32'd1);
    chk("rst_pend1", 32'(q_pend1), 32'd0);
    chk("rst_pend2", 32'(q_pend2), 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    foreach (grf_shadow[i]) grf_shadow[i] = 32'd0;
    w_a3 = 0; w_wd = 0; w_pc = 0; mdu_valid = 0; mdu_a3 = 0; mdu_wd = 0; mdu_pc = 0;
    q_a1 = 0; q_a2 = 0; reset = 1'b1;
    @(negedge clk);
    do_reset(5'd0, 5'd0);

    // W-stage only
    cycle(5'd5, 32'h1234, 32'h100, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
    chk("t1_a3", 32'(grf_a3), 32'd5);
    chk("t1_wd", grf_wd, 32'h1234);
    idle(5'd0, 5'd0);
    chk("t1_idle", 32'(grf_a3), 32'd0);

    // MDU bypass into an idle port
    cycle(5'd0, 32'd0, 32'd0, 1'b1, 5'd8, 32'hCAFE, 32'h200, 5'd8, 5'd8);
    chk("t2_a3", 32'(grf_a3), 32'd8);
    chk("t2_pend", 32'(q_pend1), 32'd0);

    // Buffering behind a busy W stage
    for (int i = 0; i < 6; i++)
      cycle(5'd20 + 5'(i), 32'(i), 32'h300 + 32'(i), i < 4, 5'd10 + 5'(i),
            32'hA0 + 32'(i), 32'h400 + 32'(i), 5'd0, 5'd0);
    chk("t3_full", 32'(mdu_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      idle(5'd0, 5'd0);
      chk("t3_drain_a3", 32'(grf_a3), 32'd10 + 32'(i));
      chk("t3_drain_wd", grf_wd, 32'hA0 + 32'(i));
    end

    // WAW kill
    cycle(5'd1, 32'd0, 32'h500, 1'b1, 5'd9, 32'h1, 32'h504, 5'd9, 5'd0);
    cycle(5'd9, 32'h2, 32'h508, 1'b0, 5'd0, 32'd0, 32'd0, 5'd9, 5'd0);
    idle(5'd9, 5'd0);
    chk("t4_killed_slot", 32'(grf_a3), 32'd0);
    idle(5'd0, 5'd0);
    chk("t4_grf9", grf_shadow[9], 32'h2);

    // Pending query
    cycle(5'd1, 32'd0, 32'd0, 1'b1, 5'd3, 32'h33, 32'h600, 5'd0, 5'd0);
    cycle(5'd2, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd3, 5'd0);
    chk("t5_pend1", 32'(q_pend1), 32'd1);
    chk("t5_pend2", 32'(q_pend2), 32'd0);
    idle(5'd0, 5'd0);

    // Reset with three entries queued
    for (int i = 0; i < 3; i++)
      cycle(5'd4, 32'd0, 32'd0, 1'b1, 5'd1 + 5'(i), 32'(i), 32'(i), 5'd0, 5'd0);
    do_reset(5'd1, 5'd2);
    idle(5'd1, 5'd2);

    // Randomized traffic with occasional reset
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      else
        cycle($urandom_range(0, 1) ? 5'($urandom_range(1, 7)) : 5'd0, $urandom, $urandom,
              $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom, $urandom,
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
